// File: rtl/minrv32_mem_pkg.sv
// minrv32_mem_pkg: shared types for the minrv32 native memory port
package minrv32_mem_pkg;

    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;

    typedef struct packed {
        logic              instr;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
        logic [3:0]        wstrb;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE,
        GNT,
        DONE
    } arb_state_t;

endpackage

// File: rtl/minrv32_mem_arbiter_pick2.sv
// mem_arb_pick2: two-way request picker, round-robin or m0-priority on ties
module mem_arb_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       rr_en_i,
    output logic       gnt_o
);

    // a tie goes to the master not served last (or m0 when fixed priority); a lone request wins outright
    always_comb begin
        gnt_o = &req_i ? (rr_en_i & ~last_i) : (req_i[1] & ~req_i[0]);
    end

endmodule

// File: rtl/minrv32_mem_arbiter.sv
// minrv32_mem_arbiter: shares one memory slave between two masters, one transaction per grant
module minrv32_mem_arbiter
    import minrv32_mem_pkg::*;
#(
    parameter bit          RR_EN          = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_valid_i,
    input  logic              m0_instr_i,
    input  logic [MEM_AW-1:0] m0_addr_i,
    input  logic [MEM_DW-1:0] m0_wdata_i,
    input  logic [3:0]        m0_wstrb_i,
    output logic              m0_ready_o,
    output logic [MEM_DW-1:0] m0_rdata_o,
    input  logic              m1_valid_i,
    input  logic              m1_instr_i,
    input  logic [MEM_AW-1:0] m1_addr_i,
    input  logic [MEM_DW-1:0] m1_wdata_i,
    input  logic [3:0]        m1_wstrb_i,
    output logic              m1_ready_o,
    output logic [MEM_DW-1:0] m1_rdata_o,
    output logic              s_valid_o,
    output logic              s_instr_o,
    output logic [MEM_AW-1:0] s_addr_o,
    output logic [MEM_DW-1:0] s_wdata_o,
    output logic [3:0]        s_wstrb_o,
    input  logic              s_ready_i,
    input  logic [MEM_DW-1:0] s_rdata_i,
    output logic              grant_id_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TMO_MAX = '1;
    localparam bit TMO_EN = TIMEOUT_CYCLES != 0;

    arb_state_t       state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    mem_req_t         m0_req, m1_req, g_req;
    logic             pick;
    logic             g_valid;
    logic             s_done;
    logic             tmo_fire;
    logic             g_ready;
    logic [MEM_DW-1:0] g_rdata;

    assign m0_req   = '{m0_instr_i, m0_addr_i, m0_wdata_i, m0_wstrb_i};
    assign m1_req   = '{m1_instr_i, m1_addr_i, m1_wdata_i, m1_wstrb_i};
    assign g_req    = grant_q ? m1_req : m0_req;
    assign g_valid  = grant_q ? m1_valid_i : m0_valid_i;
    assign s_done   = state_q == GNT && g_valid && s_ready_i;
    assign tmo_fire = TMO_EN && state_q == GNT && g_valid && !s_ready_i && tmo_q == TMO_LAST;

    mem_arb_pick2 u_pick (
        .req_i  ({m1_valid_i, m0_valid_i}),
        .last_i (last_q),
        .rr_en_i(RR_EN),
        .gnt_o  (pick)
    );

    // state register; last_grant resets to m1 so m0 wins the first tie
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end

    // next state: arbitrate in IDLE, finish on slave ready or timeout, abandon if the grantee withdraws
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        tmo_d   = '0;
        case (state_q)
            IDLE: begin
                if (m0_valid_i || m1_valid_i) begin
                    state_d = GNT;
                    grant_d = pick;
                end
            end
            GNT: begin
                if (!g_valid) begin
                    state_d = IDLE;
                end else if (s_done || tmo_fire) begin
                    state_d = DONE;
                    last_d  = grant_q;
                end else begin
                    tmo_d = tmo_q == TMO_MAX ? tmo_q : tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs: slave sees the grantee's payload, only the grantee sees ready/rdata
    always_comb begin
        s_valid_o  = state_q == GNT && !tmo_fire;
        {s_instr_o, s_addr_o, s_wdata_o, s_wstrb_o} = g_req;
        g_ready    = s_done || tmo_fire;
        g_rdata    = tmo_fire ? ERR_RDATA : s_rdata_i;
        m0_ready_o = g_ready && !grant_q;
        m1_ready_o = g_ready && grant_q;
        m0_rdata_o = state_q == GNT && !grant_q ? g_rdata : '0;
        m1_rdata_o = state_q == GNT && grant_q ? g_rdata : '0;
        grant_id_o = grant_q;
        busy_o     = state_q != IDLE;
        err_o      = tmo_fire;
    end

endmodule

// File: tb/tb_minrv32_mem_arbiter.sv
// tb_minrv32_mem_arbiter: directed and random checks of two arbiter configurations against a transaction-level model
module tb_minrv32_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        v   [2][2];
    logic        ins [2][2];
    logic [31:0] ad  [2][2];
    logic [31:0] wd  [2][2];
    logic [3:0]  ws  [2][2];
    logic        rdy [2][2];
    logic [31:0] rd  [2][2];
    logic        sv  [2];
    logic        si  [2];
    logic [31:0] sa  [2];
    logic [31:0] sw  [2];
    logic [3:0]  ss  [2];
    logic        sr  [2];
    logic [31:0] srd [2];
    logic        gid [2];
    logic        bsy [2];
    logic        er  [2];

    // instance 0: round-robin with a 4-cycle timeout; instance 1: fixed priority, no timeout
    for (genvar g = 0; g < 2; g++) begin : g_dut
        minrv32_mem_arbiter #(
            .RR_EN         (g == 0),
            .TIMEOUT_CYCLES(g == 0 ? 4 : 0),
            .ERR_RDATA     (32'hDEADBEEF)
        ) u_dut (
            .clk_i     (clk),
            .rst_i     (rst[g]),
            .m0_valid_i(v[g][0]),
            .m0_instr_i(ins[g][0]),
            .m0_addr_i (ad[g][0]),
            .m0_wdata_i(wd[g][0]),
            .m0_wstrb_i(ws[g][0]),
            .m0_ready_o(rdy[g][0]),
            .m0_rdata_o(rd[g][0]),
            .m1_valid_i(v[g][1]),
            .m1_instr_i(ins[g][1]),
            .m1_addr_i (ad[g][1]),
            .m1_wdata_i(wd[g][1]),
            .m1_wstrb_i(ws[g][1]),
            .m1_ready_o(rdy[g][1]),
            .m1_rdata_o(rd[g][1]),
            .s_valid_o (sv[g]),
            .s_instr_o (si[g]),
            .s_addr_o  (sa[g]),
            .s_wdata_o (sw[g]),
            .s_wstrb_o (ss[g]),
            .s_ready_i (sr[g]),
            .s_rdata_i (srd[g]),
            .grant_id_o(gid[g]),
            .busy_o    (bsy[g]),
            .err_o     (er[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: phase 0 waiting, 1 serving owner, 2 turnaround; waited counts stalled serving cycles
    bit go = 1'b0;
    int ph     [2] = '{0, 0};
    int who    [2] = '{0, 0};
    int last   [2] = '{1, 1};
    int waited [2] = '{0, 0};
    bit rdy_prev [2][2];
    bit m_gv, m_fire, m_ok, m_sv, m_rdy;
    int m_to;

    always @(negedge clk) begin
        if (go) begin
            for (int i = 0; i < 2; i++) begin
                m_to   = i == 0 ? 4 : 0;
                m_gv   = v[i][who[i]];
                m_fire = ph[i] == 1 && m_to > 0 && waited[i] == m_to - 1 && !sr[i] && m_gv;
                m_ok   = ph[i] == 1 && m_gv && sr[i];
                m_sv   = ph[i] == 1 && !m_fire;
                check($sformatf("i%0d s_valid", i), sv[i], m_sv);
                check($sformatf("i%0d busy", i), bsy[i], ph[i] != 0);
                check($sformatf("i%0d grant_id", i), gid[i], who[i]);
                check($sformatf("i%0d err", i), er[i], m_fire);
                if (m_sv) begin
                    check($sformatf("i%0d s_addr", i), sa[i], ad[i][who[i]]);
                    check($sformatf("i%0d s_wdata", i), sw[i], wd[i][who[i]]);
                    check($sformatf("i%0d s_instr_wstrb", i), {si[i], ss[i]}, {ins[i][who[i]], ws[i][who[i]]});
                end
                for (int x = 0; x < 2; x++) begin
                    m_rdy = (m_ok || m_fire) && who[i] == x;
                    check($sformatf("i%0d m%0d_ready", i, x), rdy[i][x], m_rdy);
                    if (m_rdy)
                        check($sformatf("i%0d m%0d_rdata", i, x), rd[i][x], m_fire ? 32'hDEADBEEF : srd[i]);
                    else if (!(ph[i] == 1 && who[i] == x))
                        check($sformatf("i%0d m%0d_rdata_idle", i, x), rd[i][x], 0);
                    rdy_prev[i][x] = rdy[i][x];
                end
                if (rst[i]) begin
                    ph[i] = 0; who[i] = 0; last[i] = 1; waited[i] = 0;
                end else if (ph[i] == 0) begin
                    if (v[i][0] || v[i][1]) begin
                        ph[i] = 1;
                        waited[i] = 0;
                        who[i] = (v[i][0] && v[i][1]) ? (i == 0 ? 1 - last[i] : 0) : (v[i][1] ? 1 : 0);
                    end
                end else if (ph[i] == 1) begin
                    if (!m_gv) begin
                        ph[i] = 0; waited[i] = 0;
                    end else if (m_ok || m_fire) begin
                        ph[i] = 2; last[i] = who[i]; waited[i] = 0;
                    end else if (waited[i] < 1000) begin
                        waited[i]++;
                    end
                end else begin
                    ph[i] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < 2; i++) begin
            v[i][0] = 1'b0; v[i][1] = 1'b0; sr[i] = 1'b0;
        end
        repeat (n) tick();
    endtask

    int gq0[$];
    int gq1[$];
    int n;
    bit found;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; sr[i] = 1'b0; srd[i] = '0;
            for (int x = 0; x < 2; x++) begin
                v[i][x] = 1'b0; ins[i][x] = 1'b0; ad[i][x] = '0; wd[i][x] = '0; ws[i][x] = '0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0; go = 1'b1;
        @(negedge clk);
        check("reset busy", bsy[0], 0);
        check("reset s_valid", sv[0], 0);
        check("reset grant_id", gid[0], 0);

        // single m0 read, slave answers two cycles after s_valid
        tick();
        ad[0][0] = 32'h0000_1000; wd[0][0] = 32'h0; ws[0][0] = 4'h0; v[0][0] = 1'b1;
        tick();
        @(negedge clk);
        check("t1 s_valid", sv[0], 1);
        check("t1 s_addr", sa[0], 32'h0000_1000);
        tick();
        tick();
        sr[0] = 1'b1; srd[0] = 32'h12345678;
        @(negedge clk);
        check("t1 m0_ready", rdy[0][0], 1);
        check("t1 m0_rdata", rd[0][0], 32'h12345678);
        check("t1 m1_ready", rdy[0][1], 0);
        tick();
        sr[0] = 1'b0; v[0][0] = 1'b0;
        @(negedge clk);
        check("t1 done ready", rdy[0][0], 0);
        check("t1 done busy", bsy[0], 1);
        idle(2);

        // both masters continuously valid from reset
        rst[0] = 1'b1; rst[1] = 1'b1;
        tick();
        rst[0] = 1'b0; rst[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ad[i][0] = 32'h100; ad[i][1] = 32'h200; v[i][0] = 1'b1; v[i][1] = 1'b1; sr[i] = 1'b1;
        end
        for (int c = 0; c < 40 && (gq0.size() < 4 || gq1.size() < 4); c++) begin
            @(negedge clk);
            if (sv[0]) begin
                gq0.push_back(int'(gid[0]));
                check("t2 rr s_addr", sa[0], gid[0] ? 32'h200 : 32'h100);
            end
            if (sv[1]) begin
                gq1.push_back(int'(gid[1]));
                check("t2 fp s_addr", sa[1], gid[1] ? 32'h200 : 32'h100);
            end
        end
        check("t2 rr grants", gq0.size() >= 4, 1);
        check("t2 fp grants", gq1.size() >= 4, 1);
        for (int k = 0; k < 4 && k < gq0.size(); k++) check($sformatf("t2 rr order %0d", k), gq0[k], k % 2);
        for (int k = 0; k < 4 && k < gq1.size(); k++) check($sformatf("t2 fp order %0d", k), gq1[k], 0);
        tick();
        v[1][0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 4 && !found; c++) begin
            @(negedge clk);
            found = sv[1] && gid[1];
        end
        check("t2 fp m1 granted", found, 1);
        check("t2 fp m1 s_addr", sa[1], 32'h200);
        tick();
        idle(3);

        // slave never answers: forced completion with error data
        v[0][1] = 1'b1; ad[0][1] = 32'h300;
        n = 0; found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge clk);
            if (rdy[0][1]) begin
                found = 1'b1;
                check("t3 rdata", rd[0][1], 32'hDEADBEEF);
                check("t3 err", er[0], 1);
                check("t3 s_valid", sv[0], 0);
            end else if (sv[0]) begin
                n++;
            end
        end
        check("t3 timeout seen", found, 1);
        check("t3 s_valid cycles", n, 3);
        tick();
        v[0][1] = 1'b0;
        @(negedge clk);
        check("t3 done busy", bsy[0], 1);
        check("t3 done s_valid", sv[0], 0);
        tick();
        @(negedge clk);
        check("t3 idle busy", bsy[0], 0);
        idle(2);

        // slave answers in the very cycle the timeout would fire
        v[0][1] = 1'b1; ad[0][1] = 32'h340;
        repeat (4) tick();
        sr[0] = 1'b1; srd[0] = 32'hCAFEF00D;
        @(negedge clk);
        check("t4 m1_ready", rdy[0][1], 1);
        check("t4 rdata", rd[0][1], 32'hCAFEF00D);
        check("t4 err", er[0], 0);
        tick();
        idle(2);

        // reset during the second granted cycle abandons the transfer
        v[0][0] = 1'b1; ad[0][0] = 32'h400;
        tick();
        tick();
        rst[0] = 1'b1;
        @(negedge clk);
        check("t5 no ready in reset", rdy[0][0], 0);
        tick();
        rst[0] = 1'b0;
        @(negedge clk);
        check("t5 s_valid after reset", sv[0], 0);
        check("t5 busy after reset", bsy[0], 0);
        tick();
        sr[0] = 1'b1; srd[0] = 32'h55AA_55AA;
        @(negedge clk);
        check("t5 regrant s_valid", sv[0], 1);
        check("t5 regrant ready", rdy[0][0], 1);
        check("t5 regrant rdata", rd[0][0], 32'h55AA_55AA);
        tick();
        idle(3);

        // random traffic: masters hold requests until ready, with rare withdrawals and resets
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                rst[i] = $urandom_range(0, 299) == 0;
                sr[i]  = $urandom_range(0, 3) == 0;
                srd[i] = $urandom;
                for (int x = 0; x < 2; x++) begin
                    if (rdy_prev[i][x] || !v[i][x]) begin
                        v[i][x]   = $urandom_range(0, 2) == 0;
                        ins[i][x] = 1'($urandom_range(0, 1));
                        ad[i][x]  = $urandom;
                        wd[i][x]  = $urandom;
                        ws[i][x]  = 4'($urandom_range(0, 15));
                    end else if ($urandom_range(0, 99) == 0) begin
                        v[i][x] = 1'b0;
                    end
                end
            end
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
